// File: rtl/openofdm_tx_pkg.sv
// Shared constants, state encoding and rate lookup for the OpenOFDM transmit bit framer.
package openofdm_tx_pkg;

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;
  localparam int FCS_BYTES    = 4;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVICE,
    ST_DATA,
    ST_FCS,
    ST_TAIL,
    ST_PAD,
    ST_DONE
  } state_t;

  // Data bits per OFDM symbol; zero marks an unsupported rate code.
  function automatic logic [8:0] rateToNdbps(input logic [3:0] rate);
    case (rate)
      RATE_6M:  return 9'd24;
      RATE_9M:  return 9'd36;
      RATE_12M: return 9'd48;
      RATE_18M: return 9'd72;
      RATE_24M: return 9'd96;
      RATE_36M: return 9'd144;
      RATE_48M: return 9'd192;
      RATE_54M: return 9'd216;
      default:  return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/openofdm_tx_crc32_serial.sv
// Bit-serial reflected CRC-32 used to generate the 802.11 FCS, one data bit per enable.
module openofdm_tx_crc32_serial
  import openofdm_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        bit_i,
  input  logic        bit_en_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC32_INIT;
    end else if (bit_en_i) begin
      crc_d = (crc_q >> 1) ^ ((crc_q[0] ^ bit_i) ? POLY_REFL : 32'd0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= CRC32_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/openofdm_tx_bit_framer.sv
// Serializes SERVICE + PSDU (+ FCS) + TAIL + PAD into the scrambler bit stream.
// Define OPENOFDM_TX_FCS_INSERT_EN to append an internally generated FCS.
module openofdm_tx_bit_framer
  import openofdm_tx_pkg::*;
#(
  parameter int LEN_WIDTH = 12,
  parameter int SYM_WIDTH = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           pkt_rate,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [7:0]           byte_in,
  input  logic                 byte_in_valid,
  output logic                 byte_in_ready,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 bit_tail,
  output logic                 bit_sym_last,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [SYM_WIDTH-1:0] n_ofdm_sym,
  output logic [8:0]           n_bit_in_last_sym
);

`ifdef OPENOFDM_TX_FCS_INSERT_EN
  localparam state_t               AFTER_DATA = ST_FCS;
  localparam logic [LEN_WIDTH-1:0] SRC_SKIP   = LEN_WIDTH'(FCS_BYTES);
`else
  localparam state_t               AFTER_DATA = ST_TAIL;
  localparam logic [LEN_WIDTH-1:0] SRC_SKIP   = '0;
`endif

  state_t               state_q;
  logic [8:0]           ndbps_q;
  logic [8:0]           symCnt_q;
  logic [4:0]           cnt_q;
  logic [LEN_WIDTH-1:0] byteCnt_q;
  logic [7:0]           byte_q;
  logic                 haveByte_q;
  logic                 done_q;
  logic                 cfgErr_q;
  logic [SYM_WIDTH-1:0] nOfdmSym_q;
  logic [8:0]           nBitLast_q;

  logic       xfer, symWrap, moreBytes, byteTake, startOk;
  logic [8:0] startNdbps;

  assign startNdbps = rateToNdbps(pkt_rate);
  assign startOk    = (startNdbps != 9'd0) && (pkt_len >= LEN_WIDTH'(FCS_BYTES));
  assign moreBytes  = (byteCnt_q != '0);
  assign symWrap    = (symCnt_q == ndbps_q - 9'd1);

  assign bit_valid = (state_q == ST_SERVICE) || (state_q == ST_FCS) || (state_q == ST_TAIL) ||
                     (state_q == ST_PAD) || ((state_q == ST_DATA) && haveByte_q);
  assign xfer      = bit_valid && bit_ready;

  // A new byte is requested only when the slot is empty or its last bit leaves this cycle.
  assign byte_in_ready = (state_q == ST_DATA) && moreBytes &&
                         (!haveByte_q || ((cnt_q[2:0] == 3'd7) && bit_ready));
  assign byteTake      = byte_in_ready && byte_in_valid;

  assign bit_tail          = (state_q == ST_TAIL);
  assign bit_sym_last      = bit_valid && symWrap;
  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign cfg_err           = cfgErr_q;
  assign n_ofdm_sym        = nOfdmSym_q;
  assign n_bit_in_last_sym = nBitLast_q;

`ifdef OPENOFDM_TX_FCS_INSERT_EN
  logic [31:0] crc;

  openofdm_tx_crc32_serial u_crc (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (state_q == ST_IDLE),
    .bit_i    (bit_out),
    .bit_en_i ((state_q == ST_DATA) && xfer),
    .crc_o    (crc)
  );
`endif

  always_comb begin
    bit_out = 1'b0;
    case (state_q)
      ST_DATA: bit_out = byte_q[cnt_q[2:0]];
`ifdef OPENOFDM_TX_FCS_INSERT_EN
      ST_FCS:  bit_out = ~crc[cnt_q];
`endif
      default: bit_out = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ndbps_q    <= '0;
      symCnt_q   <= '0;
      cnt_q      <= '0;
      byteCnt_q  <= '0;
      byte_q     <= '0;
      haveByte_q <= 1'b0;
      done_q     <= 1'b0;
      cfgErr_q   <= 1'b0;
      nOfdmSym_q <= '0;
      nBitLast_q <= '0;
    end else begin
      done_q   <= 1'b0;
      cfgErr_q <= 1'b0;
      if (xfer) begin
        symCnt_q <= symWrap ? 9'd0 : symCnt_q + 9'd1;
        if (symWrap) nOfdmSym_q <= nOfdmSym_q + SYM_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!startOk) begin
              cfgErr_q <= 1'b1;
            end else begin
              state_q    <= ST_SERVICE;
              ndbps_q    <= startNdbps;
              byteCnt_q  <= pkt_len - SRC_SKIP;
              cnt_q      <= '0;
              symCnt_q   <= '0;
              nOfdmSym_q <= '0;
              nBitLast_q <= '0;
              haveByte_q <= 1'b0;
            end
          end
        end
        ST_SERVICE: begin
          if (xfer) begin
            if (cnt_q == 5'(SERVICE_BITS - 1)) begin
              cnt_q   <= '0;
              state_q <= moreBytes ? ST_DATA : AFTER_DATA;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (byteTake) begin
            byte_q    <= byte_in;
            byteCnt_q <= byteCnt_q - LEN_WIDTH'(1);
          end
          if (xfer && (cnt_q[2:0] == 3'd7)) begin
            cnt_q      <= '0;
            haveByte_q <= byteTake;
            if (!moreBytes) state_q <= AFTER_DATA;
          end else if (xfer) begin
            cnt_q <= cnt_q + 5'd1;
          end else if (byteTake) begin
            haveByte_q <= 1'b1;
          end
        end
`ifdef OPENOFDM_TX_FCS_INSERT_EN
        ST_FCS: begin
          if (xfer) begin
            if (cnt_q == 5'd31) begin
              cnt_q   <= '0;
              state_q <= ST_TAIL;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
`endif
        // Padding is skipped when the last tail bit happens to close a symbol.
        ST_TAIL: begin
          if (xfer) begin
            if (cnt_q == 5'(TAIL_BITS - 1)) begin
              cnt_q      <= '0;
              nBitLast_q <= symCnt_q + 9'd1;
              state_q    <= symWrap ? ST_DONE : ST_PAD;
              done_q     <= symWrap;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ST_PAD: begin
          if (xfer && symWrap) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_openofdm_tx_bit_framer.sv
// Directed self-checking bench for openofdm_tx_bit_framer; follows OPENOFDM_TX_FCS_INSERT_EN.
module tb_openofdm_tx_bit_framer;

  localparam int LEN_WIDTH   = 12;
  localparam int SYM_WIDTH   = 15;
  localparam int CYCLE_LIMIT = 4000;
`ifdef OPENOFDM_TX_FCS_INSERT_EN
  localparam bit FCS_INTERNAL = 1'b1;
`else
  localparam bit FCS_INTERNAL = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [3:0]           pkt_rate;
  logic [LEN_WIDTH-1:0] pkt_len;
  logic [7:0]           byte_in;
  logic                 byte_in_valid;
  logic                 byte_in_ready;
  logic                 bit_out;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 bit_tail;
  logic                 bit_sym_last;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;
  logic [SYM_WIDTH-1:0] n_ofdm_sym;
  logic [8:0]           n_bit_in_last_sym;

  always #5 clock = ~clock;

  openofdm_tx_bit_framer #(.LEN_WIDTH(LEN_WIDTH), .SYM_WIDTH(SYM_WIDTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .pkt_rate          (pkt_rate),
    .pkt_len           (pkt_len),
    .byte_in           (byte_in),
    .byte_in_valid     (byte_in_valid),
    .byte_in_ready     (byte_in_ready),
    .bit_out           (bit_out),
    .bit_valid         (bit_valid),
    .bit_ready         (bit_ready),
    .bit_tail          (bit_tail),
    .bit_sym_last      (bit_sym_last),
    .busy              (busy),
    .done              (done),
    .cfg_err           (cfg_err),
    .n_ofdm_sym        (n_ofdm_sym),
    .n_bit_in_last_sym (n_bit_in_last_sym)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] payload[$];
  logic [7:0] expBytes[$];
  logic [7:0] srcBytes[$];
  logic       expBits[$];
  logic       expTail[$];
  logic       expLast[$];
  logic       gotBits[$];
  logic       gotTail[$];
  logic       gotLast[$];
  int         expSym, expLastBits, taken, holdErr, seenSym, seenLastBits;
  bit         finished, timedOut;

  // Reference framing: reflected CRC-32 over the payload, then the full DATA-field bit stream.
  task automatic prepPacket(input int ndbps);
    logic [31:0] crc;
    int          dataBits;
    crc = 32'hFFFFFFFF;
    foreach (payload[i]) begin
      crc = crc ^ {24'd0, payload[i]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    expBytes = payload;
    for (int b = 0; b < 4; b++) expBytes.push_back(crc[8*b +: 8]);
    if (FCS_INTERNAL) srcBytes = payload;
    else              srcBytes = expBytes;
    expBits.delete(); expTail.delete(); expLast.delete();
    for (int i = 0; i < 16; i++) begin expBits.push_back(1'b0); expTail.push_back(1'b0); end
    foreach (expBytes[b])
      for (int k = 0; k < 8; k++) begin expBits.push_back(expBytes[b][k]); expTail.push_back(1'b0); end
    for (int i = 0; i < 6; i++) begin expBits.push_back(1'b0); expTail.push_back(1'b1); end
    dataBits = expBits.size();
    while ((expBits.size() % ndbps) != 0) begin expBits.push_back(1'b0); expTail.push_back(1'b0); end
    foreach (expBits[i]) expLast.push_back(((i + 1) % ndbps) == 0);
    expSym      = expBits.size() / ndbps;
    expLastBits = dataBits - (expSym - 1) * ndbps;
  endtask

  // Drives one packet and records every transferred bit; comparisons live in the test tasks.
  task automatic runPacket(input logic [3:0] rate, input int len, input bit throttle,
                           input int stallAt, input int abortAt, input int spuriousAt);
    int cyc, stallLeft;
    bit stalled, stalling, prevPend, prevBit, prevTail, prevLast;
    gotBits.delete(); gotTail.delete(); gotLast.delete();
    taken = 0; holdErr = 0; finished = 0; timedOut = 0; seenSym = -1; seenLastBits = -1;
    cyc = 0; stallLeft = 0; stalled = 0; prevPend = 0; prevBit = 0; prevTail = 0; prevLast = 0;
    @(negedge clock);
    start    = 1'b1;
    pkt_rate = rate;
    pkt_len  = LEN_WIDTH'(len);
    while (!finished && cyc < CYCLE_LIMIT) begin
      if (cyc == spuriousAt) begin start = 1'b1; pkt_rate = 4'b0011; pkt_len = 12'd200; end
      bit_ready = throttle ? ((cyc % 2) == 1) : 1'b1;
      if (!stalled && taken == stallAt) begin stalled = 1; stallLeft = 5; end
      stalling      = stallLeft > 0;
      byte_in_valid = !stalling && (taken < srcBytes.size());
      byte_in       = (taken < srcBytes.size()) ? srcBytes[taken] : 8'h00;
      #1;
      if (stalling && byte_in_ready) stallLeft--;
      if (done) begin finished = 1; seenSym = int'(n_ofdm_sym); seenLastBits = int'(n_bit_in_last_sym); end
      if (prevPend && (!bit_valid || bit_out !== prevBit || bit_tail !== prevTail || bit_sym_last !== prevLast))
        holdErr++;
      prevPend = bit_valid && !bit_ready;
      prevBit  = bit_out; prevTail = bit_tail; prevLast = bit_sym_last;
      if (bit_valid && bit_ready) begin
        gotBits.push_back(bit_out); gotTail.push_back(bit_tail); gotLast.push_back(bit_sym_last);
      end
      if (byte_in_valid && byte_in_ready) taken++;
      if (abortAt >= 0 && taken >= abortAt) break;
      @(negedge clock);
      start = 1'b0;
      cyc++;
    end
    if (!finished && abortAt < 0) timedOut = 1;
    byte_in_valid = 1'b0;
    bit_ready     = 1'b1;
  endtask

  function automatic int countBitErrors();
    int n = 0;
    if (gotBits.size() != expBits.size()) return -1;
    foreach (gotBits[i]) if (gotBits[i] !== expBits[i] || gotTail[i] !== expTail[i] || gotLast[i] !== expLast[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pkt_rate = '0; pkt_len = '0;
    byte_in = '0; byte_in_valid = 1'b0; bit_ready = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({bit_valid, byte_in_ready, busy, done, cfg_err, bit_out, bit_tail, bit_sym_last} !== 8'b0) begin
      bad++; $display("[TB] FAIL reset_outputs: got %b expected 00000000",
                      {bit_valid, byte_in_ready, busy, done, cfg_err, bit_out, bit_tail, bit_sym_last});
    end
    total++;
    if (n_ofdm_sym !== '0 || n_bit_in_last_sym !== '0) begin
      bad++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", n_ofdm_sym, n_bit_in_last_sym);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || bit_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_idle: got busy=%b valid=%b expected 0/0", busy, bit_valid);
    end
  endtask

  task automatic test_no_payload();
    int tailErr, lastErr, zeroErr;
    payload.delete();
    prepPacket(24);
    runPacket(4'b1101, 4, 1'b0, -1, -1, -1);
    total++;
    if (timedOut) begin bad++; $display("[TB] FAIL nopay_timeout: got no done expected done"); end
    total++;
    if (gotBits.size() != 72) begin bad++; $display("[TB] FAIL nopay_bits: got %0d expected 72", gotBits.size()); end
    total++;
    if (seenSym != 3) begin bad++; $display("[TB] FAIL nopay_nsym: got %0d expected 3", seenSym); end
    total++;
    if (seenLastBits != 6) begin bad++; $display("[TB] FAIL nopay_lastbits: got %0d expected 6", seenLastBits); end
    tailErr = 0; lastErr = 0; zeroErr = 0;
    foreach (gotBits[i]) begin
      if (gotBits[i] !== 1'b0) zeroErr++;
      if (gotTail[i] !== (i >= 48 && i <= 53)) tailErr++;
      if (gotLast[i] !== (i == 23 || i == 47 || i == 71)) lastErr++;
    end
    total++;
    if (zeroErr != 0) begin bad++; $display("[TB] FAIL nopay_zero: got %0d nonzero bits expected 0", zeroErr); end
    total++;
    if (tailErr != 0) begin bad++; $display("[TB] FAIL nopay_tail: got %0d misplaced expected 0", tailErr); end
    total++;
    if (lastErr != 0) begin bad++; $display("[TB] FAIL nopay_symlast: got %0d misplaced expected 0", lastErr); end
    total++;
    if (taken != srcBytes.size()) begin bad++; $display("[TB] FAIL nopay_bytes: got %0d expected %0d", taken, srcBytes.size()); end
  endtask

  task automatic test_long_packet();
    int errs;
    payload.delete();
    for (int i = 0; i < 96; i++) payload.push_back(8'((i * 37 + 5) & 255));
    prepPacket(216);
    runPacket(4'b0011, 100, 1'b0, -1, -1, -1);
    total++;
    if (gotBits.size() != 864) begin bad++; $display("[TB] FAIL long_bits: got %0d expected 864", gotBits.size()); end
    total++;
    if (seenSym != 4) begin bad++; $display("[TB] FAIL long_nsym: got %0d expected 4", seenSym); end
    total++;
    if (seenLastBits != 174) begin bad++; $display("[TB] FAIL long_lastbits: got %0d expected 174", seenLastBits); end
    errs = countBitErrors();
    total++;
    if (errs != 0) begin bad++; $display("[TB] FAIL long_stream: got %0d errors expected 0", errs); end
    total++;
    if (taken != (FCS_INTERNAL ? 96 : 100)) begin
      bad++; $display("[TB] FAIL long_bytes: got %0d expected %0d", taken, FCS_INTERNAL ? 96 : 100);
    end
  endtask

  task automatic test_fcs_value();
    logic [7:0] fcsExp[4];
    logic [7:0] got;
    string      s;
    fcsExp[0] = 8'h26; fcsExp[1] = 8'h39; fcsExp[2] = 8'hF4; fcsExp[3] = 8'hCB;
    s = "123456789";
    payload.delete();
    for (int i = 0; i < s.len(); i++) payload.push_back(s[i]);
    prepPacket(24);
    runPacket(4'b1101, 13, 1'b0, -1, -1, -1);
    total++;
    if (gotBits.size() != 144) begin bad++; $display("[TB] FAIL fcs_bits: got %0d expected 144", gotBits.size()); end
    total++;
    if (seenSym != 6 || seenLastBits != 6) begin
      bad++; $display("[TB] FAIL fcs_phylen: got %0d/%0d expected 6/6", seenSym, seenLastBits);
    end
    for (int b = 0; b < 4; b++) begin
      got = 8'h00;
      for (int k = 0; k < 8; k++)
        if (88 + 8*b + k < gotBits.size()) got[k] = gotBits[88 + 8*b + k];
      total++;
      if (got !== fcsExp[b]) begin bad++; $display("[TB] FAIL fcs_byte%0d: got %02h expected %02h", b, got, fcsExp[b]); end
    end
  endtask

  task automatic test_cfg_error();
    logic [3:0] rates[2];
    int         lens[2];
    rates[0] = 4'b0000; lens[0] = 50;
    rates[1] = 4'b1101; lens[1] = 3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      start = 1'b1; pkt_rate = rates[c]; pkt_len = LEN_WIDTH'(lens[c]);
      @(negedge clock);
      start = 1'b0;
      total++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || bit_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL cfgerr_pulse%0d: got err=%b busy=%b valid=%b expected 1/0/0", c, cfg_err, busy, bit_valid);
      end
      @(negedge clock);
      total++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL cfgerr_clear%0d: got err=%b busy=%b valid=%b expected 0/0/0", c, cfg_err, busy, bit_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int errs;
    payload.delete();
    for (int i = 0; i < 16; i++) payload.push_back(8'((i * 11 + 1) & 255));
    prepPacket(24);
    runPacket(4'b1101, 20, 1'b1, 6, -1, -1);
    errs = countBitErrors();
    total++;
    if (timedOut || errs != 0) begin bad++; $display("[TB] FAIL bp_stream: got %0d errors expected 0", errs); end
    total++;
    if (gotBits.size() != 192 || seenSym != 8 || seenLastBits != 14) begin
      bad++; $display("[TB] FAIL bp_phylen: got %0d/%0d/%0d expected 192/8/14", gotBits.size(), seenSym, seenLastBits);
    end
    total++;
    if (holdErr != 0) begin bad++; $display("[TB] FAIL bp_hold: got %0d unstable expected 0", holdErr); end
    total++;
    if (taken != srcBytes.size()) begin bad++; $display("[TB] FAIL bp_bytes: got %0d expected %0d", taken, srcBytes.size()); end
  endtask

  task automatic test_reset_midpacket();
    int errs, doneCount;
    payload.delete();
    for (int i = 0; i < 36; i++) payload.push_back(8'(i + 100));
    prepPacket(24);
    runPacket(4'b1101, 40, 1'b0, -1, 10, -1);
    total++;
    if (busy !== 1'b1 || taken != 10) begin bad++; $display("[TB] FAIL abort_point: got busy=%b bytes=%0d expected 1/10", busy, taken); end
    reset = 1'b1;
    #1;
    total++;
    if ({bit_valid, byte_in_ready, busy, done, bit_tail, bit_sym_last} !== 6'b0 || n_ofdm_sym !== '0) begin
      bad++; $display("[TB] FAIL abort_clear: got %b sym=%0d expected 000000 sym=0",
                      {bit_valid, byte_in_ready, busy, done, bit_tail, bit_sym_last}, n_ofdm_sym);
    end
    @(negedge clock);
    reset = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done || busy) doneCount++;
    end
    total++;
    if (doneCount != 0) begin bad++; $display("[TB] FAIL abort_residual: got %0d cycles expected 0", doneCount); end
    payload.delete();
    for (int i = 0; i < 26; i++) payload.push_back(8'(255 - 3 * i));
    prepPacket(48);
    runPacket(4'b0101, 30, 1'b0, -1, -1, 40);
    errs = countBitErrors();
    total++;
    if (timedOut || errs != 0) begin bad++; $display("[TB] FAIL restart_stream: got %0d errors expected 0", errs); end
    total++;
    if (seenSym != 6 || seenLastBits != 22) begin
      bad++; $display("[TB] FAIL restart_phylen: got %0d/%0d expected 6/22", seenSym, seenLastBits);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    payload.delete();
    for (int i = 0; i < 5; i++) payload.push_back(8'(8'hA5 ^ i));
    prepPacket(36);
    runPacket(4'b1111, 9, 1'b0, -1, -1, -1);
    errs = countBitErrors();
    total++;
    if (timedOut || errs != 0 || seenSym != 3 || seenLastBits != 22) begin
      bad++; $display("[TB] FAIL b2b_first: got err=%0d sym=%0d last=%0d expected 0/3/22", errs, seenSym, seenLastBits);
    end
    payload.delete();
    payload.push_back(8'h81); payload.push_back(8'h7E);
    prepPacket(72);
    runPacket(4'b0111, 6, 1'b0, -1, -1, -1);
    errs = countBitErrors();
    total++;
    if (timedOut || errs != 0 || seenSym != 1 || seenLastBits != 70) begin
      bad++; $display("[TB] FAIL b2b_second: got err=%0d sym=%0d last=%0d expected 0/1/70", errs, seenSym, seenLastBits);
    end
  endtask

  initial begin
    test_reset();
    test_no_payload();
    test_long_packet();
    test_fcs_value();
    test_cfg_error();
    test_backpressure();
    test_reset_midpacket();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/openofdm_tx_bit_framer.md
Name: openofdm_tx_bit_framer

Overview:
- Transmit-side counterpart of the receiver's byte/FCS output path.
- Pulls PSDU payload bytes from the tx buffer and serializes the 802.11a/g DATA field bit by bit into the scrambler/convolutional encoder: SERVICE(16) + PSDU + FCS(32) + TAIL(6) + PAD.
- Reports n_ofdm_sym and n_bit_in_last_sym, mirroring the rx phy-length outputs.
- Legacy rates only; no HT.

Parameters:
- LEN_WIDTH, 12, width of pkt_len (PSDU bytes including FCS).
- SYM_WIDTH, 15, width of the n_ofdm_sym counter.

Ports:
- clock  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latches pkt_rate/pkt_len when IDLE
- pkt_rate  in  4  legacy SIGNAL rate code
- pkt_len  in  LEN_WIDTH  PSDU length in bytes, including the 4 FCS bytes
- byte_in  in  8  payload byte
- byte_in_valid  in  1  byte_in is valid
- byte_in_ready  out  1  byte accepted when valid&ready
- bit_out  out  1  serial DATA-field bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  downstream accept
- bit_tail  out  1  current bit is a tail bit (scrambler must force it to zero)
- bit_sym_last  out  1  last bit of an OFDM symbol
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after the final pad bit is accepted
- cfg_err  out  1  one-cycle pulse on a rejected start
- n_ofdm_sym  out  SYM_WIDTH  symbols emitted, valid with done
- n_bit_in_last_sym  out  9  data bits (non-pad) in the last symbol, valid with done

Behaviour:
- Reset value of every output is 0, except byte_in_ready, which is also 0. Reset mid-packet aborts to IDLE immediately and leaves no residual done.
- Rate→ndbps mapping:
  - 1101→24, 1111→36, 0101→48, 0111→72
  - 1001→96, 1011→144, 0001→192, 0011→216
  - Any other code, or pkt_len<4, on start: cfg_err pulses the next cycle and the block stays IDLE.
- start while busy is ignored.
- Handshake: a bit transfers when bit_valid&bit_ready. bit_out, bit_tail and bit_sym_last are held stable while bit_valid&!bit_ready.
- Latency: start in cycle t → bit_valid=1 in t+1 with the first SERVICE bit.
- States:
  - IDLE → SERVICE on a valid start.
  - SERVICE: 16 zero bits → DATA.
  - DATA: pkt_len-4 bytes, LSB first. byte_in_ready=1 only in the cycle that transfers bit 7 of the current byte, or before the first byte; bit_valid=0 while waiting for byte_in_valid.
  - FCS: 32 bits → TAIL.
  - TAIL: 6 zero bits with bit_tail=1 → PAD if the symbol bit counter≠0, else DONE.
  - PAD: zero bits until the symbol counter wraps → DONE.
  - DONE: done pulse, one cycle → IDLE.
- If pkt_len=4, DATA is skipped (SERVICE→FCS).
- Symbol bit counter: increments on each transfer and wraps at ndbps-1 with bit_sym_last=1; n_ofdm_sym increments on each wrap.
- n_bit_in_last_sym = counter value +1 at the last tail bit.
- FCS: CRC-32 (poly 0x04C11DB7, reflected), init 0xFFFFFFFF, updated bit-serially on every DATA bit transferred. FCS bits are emitted as the complemented register, LSB first, so bytes appear little-endian.
- A byte offered with byte_in_valid outside DATA is not consumed.

Optional Feature:
- OPENOFDM_TX_FCS_INSERT_EN defined: FCS is generated internally as above.
- Undefined: the FCS state is removed, all pkt_len bytes are pulled from byte_in (the source supplies the FCS), and the CRC sub-module is not instantiated.

Decomposition:
- Shared package openofdm_tx_pkg holds:
  - rate code constants and the rate→ndbps function
  - state enum
  - SERVICE_BITS=16, TAIL_BITS=6, FCS_BYTES=4
  - CRC32_POLY and CRC32_INIT
- One sub-module: openofdm_tx_crc32_serial (clear, bit, bit_en, crc[31:0]).

Test Plan:
- rate=1101, pkt_len=4 (no payload), bit_ready=1 → 54 data bits + 18 pad = 72 bits; n_ofdm_sym=3; n_bit_in_last_sym=6; bit_tail on bits 48–53; bit_sym_last on bits 23/47/71.
- rate=0011, pkt_len=100 → 822 data bits, 42 pad, n_ofdm_sym=4, n_bit_in_last_sym=174; 96 bytes consumed.
- rate=1101, payload ASCII "123456789", pkt_len=13 → FCS bytes 0x26,0x39,0xF4,0xCB after the payload bits.
- start with rate=0000, or with pkt_len=3 → cfg_err pulse at t+1, busy stays 0, no bit_valid.
- bit_ready toggled 1/0 every cycle and byte_in_valid dropped for 5 cycles mid-DATA → identical bit sequence to the free-running case, held outputs stable, no byte lost or duplicated.
- reset asserted in DATA after 10 bytes → all outputs 0 asynchronously; a new start then produces a correct packet from SERVICE.
